// File: rtl/sync_gearbox_fifo.sv
// Synchronous FIFO with integer upsize/downsize/pass-through width conversion.
// Optional macro SYNC_GEARBOX_FIFO_FLUSH_EN adds flush_i to close partial entries.
module sync_gearbox_fifo #(
    parameter int IN_DATA_WIDTH   = 8,
    parameter int OUT_DATA_WIDTH  = 32,
    parameter int FIFO_DEPTH      = 8,
    parameter     CONCAT_ORDER    = "LSB",
    parameter int ALMOST_FULL_TH  = FIFO_DEPTH - 1,
    parameter int ALMOST_EMPTY_TH = 1,
    parameter int ADDR_WIDTH      = $clog2(FIFO_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [IN_DATA_WIDTH-1:0]  data_i,
    input  logic                      wr_valid_i,
    output logic                      wr_ready_o,
    output logic [OUT_DATA_WIDTH-1:0] data_o,
    input  logic                      rd_valid_i,
    output logic                      rd_ready_o,
    output logic                      empty_o,
    output logic                      full_o,
    output logic                      almost_full_o,
    output logic                      almost_empty_o,
`ifdef SYNC_GEARBOX_FIFO_FLUSH_EN
    input  logic                      flush_i,
`endif
    output logic [ADDR_WIDTH:0]       counter
);

    localparam int WIDE      = (IN_DATA_WIDTH > OUT_DATA_WIDTH) ? IN_DATA_WIDTH : OUT_DATA_WIDTH;
    localparam int NARROW    = (IN_DATA_WIDTH > OUT_DATA_WIDTH) ? OUT_DATA_WIDTH : IN_DATA_WIDTH;
    localparam int RATIO     = WIDE / NARROW;
    localparam bit UPSIZE    = (IN_DATA_WIDTH < OUT_DATA_WIDTH);
    localparam bit DOWNSIZE  = (IN_DATA_WIDTH > OUT_DATA_WIDTH);
    localparam bit MSB_FIRST = (CONCAT_ORDER == "MSB");
    localparam logic [ADDR_WIDTH:0] FULL_XOR  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] LAST_SLOT = (ADDR_WIDTH + 1)'(FIFO_DEPTH - 1);

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDE-1:0]       mem_q [FIFO_DEPTH];

    logic                  full, empty;
    logic                  wr_hsk, rd_hsk;
    logic                  wr_block;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [RATIO-1:0]      lane_we;
    logic [WIDE-1:0]       wdata;

    assign counter        = wr_ptr_q - rd_ptr_q;
    assign full           = ((wr_ptr_q ^ rd_ptr_q) == FULL_XOR);
    assign empty          = (wr_ptr_q == rd_ptr_q);
    assign wr_ready_o     = ~full & ~wr_block;
    assign full_o         = ~wr_ready_o;
    assign rd_ready_o     = ~empty;
    assign empty_o        = empty;
    assign almost_full_o  = (int'(counter) >= ALMOST_FULL_TH);
    assign almost_empty_o = (int'(counter) <= ALMOST_EMPTY_TH);
    assign wr_hsk         = wr_valid_i & wr_ready_o;
    assign rd_hsk         = rd_valid_i & rd_ready_o;
    assign raddr          = rd_ptr_q[ADDR_WIDTH-1:0];

    // Write side: upsize assembles narrow lanes into the entry at wr_ptr.
    if (UPSIZE) begin : g_wr_up
        localparam int LANE_W = $clog2(RATIO);
        localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

        logic [LANE_W-1:0] wr_lane_q, wr_lane_d;
        logic [LANE_W-1:0] tgt_lane, phys_lane;
        logic              flush_wr;

`ifdef SYNC_GEARBOX_FIFO_FLUSH_EN
        assign flush_wr = flush_i & (wr_lane_q != '0);
`else
        assign flush_wr = 1'b0;
`endif
        // After a flush commit the coincident beat needs the following entry to be free.
        assign wr_block = flush_wr & (counter == LAST_SLOT);

        always_comb begin
            tgt_lane  = flush_wr ? '0 : wr_lane_q;
            phys_lane = MSB_FIRST ? (LAST_LANE - tgt_lane) : tgt_lane;
            waddr     = flush_wr ? (wr_ptr_q[ADDR_WIDTH-1:0] + 1'b1) : wr_ptr_q[ADDR_WIDTH-1:0];
            wdata     = '0;
            wdata[int'(phys_lane)*NARROW +: NARROW] = data_i;
            // Lane 0 writes the whole entry so untouched lanes read back as zero.
            lane_we   = (tgt_lane == '0) ? '1 : (RATIO'(1) << phys_lane);
            mem_we    = wr_hsk;
            wr_ptr_d  = wr_ptr_q;
            wr_lane_d = wr_lane_q;
            if (flush_wr) begin
                wr_ptr_d  = wr_ptr_q + 1'b1;
                wr_lane_d = wr_hsk ? LANE_W'(1) : '0;
            end else if (wr_hsk) begin
                if (wr_lane_q == LAST_LANE) begin
                    wr_lane_d = '0;
                    wr_ptr_d  = wr_ptr_q + 1'b1;
                end else begin
                    wr_lane_d = wr_lane_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) wr_lane_q <= '0;
            else        wr_lane_q <= wr_lane_d;
        end
    end else begin : g_wr_wide
        assign wr_block = 1'b0;

        always_comb begin
            waddr    = wr_ptr_q[ADDR_WIDTH-1:0];
            wdata    = data_i;
            lane_we  = '1;
            mem_we   = wr_hsk;
            wr_ptr_d = wr_hsk ? (wr_ptr_q + 1'b1) : wr_ptr_q;
        end
    end

    // Read side: downsize walks the head entry one narrow lane per handshake.
    if (DOWNSIZE) begin : g_rd_down
        localparam int LANE_W = $clog2(RATIO);
        localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

        logic [LANE_W-1:0] rd_lane_q, rd_lane_d;
        logic [LANE_W-1:0] phys_lane;
        logic [WIDE-1:0]   head;
        logic              flush_rd;

`ifdef SYNC_GEARBOX_FIFO_FLUSH_EN
        assign flush_rd = flush_i & (rd_lane_q != '0);
`else
        assign flush_rd = 1'b0;
`endif

        always_comb begin
            phys_lane = MSB_FIRST ? (LAST_LANE - rd_lane_q) : rd_lane_q;
            head      = mem_q[raddr];
            data_o    = head[int'(phys_lane)*NARROW +: NARROW];
            rd_ptr_d  = rd_ptr_q;
            rd_lane_d = rd_lane_q;
            if (flush_rd) begin
                rd_ptr_d  = rd_ptr_q + 1'b1;
                rd_lane_d = '0;
            end else if (rd_hsk) begin
                if (rd_lane_q == LAST_LANE) begin
                    rd_lane_d = '0;
                    rd_ptr_d  = rd_ptr_q + 1'b1;
                end else begin
                    rd_lane_d = rd_lane_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) rd_lane_q <= '0;
            else        rd_lane_q <= rd_lane_d;
        end
    end else begin : g_rd_wide
        always_comb begin
            data_o   = mem_q[raddr];
            rd_ptr_d = rd_hsk ? (rd_ptr_q + 1'b1) : rd_ptr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; only committed entries are ever presented.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int l = 0; l < RATIO; l++) begin
                if (lane_we[l]) mem_q[waddr][l*NARROW +: NARROW] <= wdata[l*NARROW +: NARROW];
            end
        end
    end

endmodule
